// File: rtl/mlp_feed_pkg.sv
// Shared types and constants for the MLP feed sequencer and its optional
// shadow checker.
package mlp_feed_pkg;

  localparam int PAIR_W = 8;
  localparam int NIB_W  = 4;
  localparam int ACC_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN
  } state_t;

  // Negative two's-complement totals clamp to zero; zero and positive pass through.
  function automatic logic [ACC_W-1:0] relu(input logic [ACC_W-1:0] v);
    return v[ACC_W-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/mlp_feed_check.sv
// Shadow accumulator that recomputes the MAC total from the streamed pairs
// and flags a disagreement with the MAC's ReLU output at drain time.
module mlp_feed_check
  import mlp_feed_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              pair_valid,
  input  logic [PAIR_W-1:0] pair,
  input  logic              capture,
  input  logic              err_clr,
  input  logic [ACC_W-1:0]  relu_in,
  output logic              check_err
);

  logic signed [NIB_W-1:0]   i_val;
  logic signed [NIB_W-1:0]   w_val;
  logic signed [2*NIB_W-1:0] prod;
  logic [ACC_W-1:0]          prod_ext;
  logic [ACC_W-1:0]          shadow;

  assign i_val    = pair[NIB_W-1:0];
  assign w_val    = pair[PAIR_W-1:NIB_W];
  assign prod     = i_val * w_val;
  assign prod_ext = {{(ACC_W-2*NIB_W){prod[2*NIB_W-1]}}, prod};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow    <= '0;
      check_err <= 1'b0;
    end else begin
      if (clr) begin
        shadow <= '0;
      end else if (pair_valid) begin
        shadow <= shadow + prod_ext;
      end

      if (err_clr) begin
        check_err <= 1'b0;
      end else if (capture) begin
        check_err <= (relu(shadow) != relu_in);
      end
    end
  end

endmodule

// File: rtl/mlp_feed_ctrl.sv
// Buffers (input, weight) nibble pairs and streams them into the neuron MAC,
// then captures its ReLU result. Optional checker: define MLP_FEED_CHECK_EN.
module mlp_feed_ctrl
  import mlp_feed_pkg::*;
#(
  parameter  int N_TERMS = 8,
  localparam int CNT_W   = $clog2(N_TERMS + 1),
  localparam int IDX_W   = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [PAIR_W-1:0] load_data,
  input  logic              load_last,
  input  logic              start,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic [PAIR_W-1:0] pair_out,
  output logic              pair_valid,
  output logic              acc_clr,
  input  logic [ACC_W-1:0]  relu_in,
  output logic [ACC_W-1:0]  result,
`ifdef MLP_FEED_CHECK_EN
  output logic              result_valid,
  output logic              check_err
`else
  output logic              result_valid
`endif
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(N_TERMS);

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic [IDX_W-1:0]  idx_inc;
  logic [IDX_W-1:0]  wr_idx;
  logic [CNT_W-1:0]  cnt_inc;
  logic [PAIR_W-1:0] pair_next;
  logic [PAIR_W-1:0] pair_buf [N_TERMS];
  logic              sealed;
  logic              load_fire;
  logic              run_start;
  logic              idx_last;

  assign load_ready = (state == S_IDLE) && !start && (count < FULL);
  assign load_fire  = load_valid && load_ready;
  assign run_start  = (state == S_IDLE) && start && (count != '0);
  assign cnt_inc    = count + CNT_W'(1);
  assign idx_inc    = idx + IDX_W'(1);
  assign idx_last   = (CNT_W'(idx) == count - CNT_W'(1));
  // A beat arriving after a sealed vector starts a fresh vector at slot 0.
  assign wr_idx     = sealed ? '0 : count[IDX_W-1:0];

  always_comb begin
    state_next = state;
    idx_next   = idx;
    pair_next  = '0;
    case (state)
      S_IDLE: begin
        if (run_start) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        state_next = S_STREAM;
        idx_next   = '0;
        pair_next  = pair_buf[0];
      end
      S_STREAM: begin
        if (idx_last) begin
          state_next = S_DRAIN;
        end else begin
          idx_next  = idx_inc;
          pair_next = pair_buf[idx_inc];
        end
      end
      S_DRAIN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      count        <= '0;
      sealed       <= 1'b0;
      pair_out     <= '0;
      pair_valid   <= 1'b0;
      acc_clr      <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_next;
      idx          <= idx_next;
      pair_out     <= pair_next;
      pair_valid   <= (state_next == S_STREAM);
      acc_clr      <= (state_next == S_CLEAR);
      busy         <= (state_next != S_IDLE);
      result_valid <= (state == S_DRAIN);
      if (state == S_DRAIN) result <= relu_in;

      if (load_fire) begin
        if (sealed) begin
          count  <= CNT_W'(1);
          sealed <= load_last || (N_TERMS == 1);
        end else begin
          count  <= cnt_inc;
          sealed <= load_last || (cnt_inc == FULL);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire) pair_buf[wr_idx] <= load_data;
  end

`ifdef MLP_FEED_CHECK_EN
  mlp_feed_check u_check (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (acc_clr),
    .pair_valid (pair_valid),
    .pair       (pair_out),
    .capture    (state == S_DRAIN),
    .err_clr    (run_start),
    .relu_in    (relu_in),
    .check_err  (check_err)
  );
`endif

endmodule

// File: tb/tb_mlp_feed_ctrl.sv
// Directed self-checking bench for mlp_feed_ctrl with a behavioural MAC model
// driven by pair_out/acc_clr and feeding relu_in back.
module tb_mlp_feed_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_data;
  logic        load_last;
  logic        start;
  logic        busy;
  logic [3:0]  count;
  logic [7:0]  pair_out;
  logic        pair_valid;
  logic        acc_clr;
  logic [15:0] relu_in;
  logic [15:0] result;
  logic        result_valid;
`ifdef MLP_FEED_CHECK_EN
  logic        check_err;
`endif

  int tests;
  int failures;

  logic [15:0] mac_total;

  mlp_feed_ctrl #(.N_TERMS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .load_last    (load_last),
    .start        (start),
    .busy         (busy),
    .count        (count),
    .pair_out     (pair_out),
    .pair_valid   (pair_valid),
    .acc_clr      (acc_clr),
    .relu_in      (relu_in),
    .result       (result),
`ifdef MLP_FEED_CHECK_EN
    .result_valid (result_valid),
    .check_err    (check_err)
`else
    .result_valid (result_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mac_prod(input logic [7:0] p);
    logic signed [3:0] iv;
    logic signed [3:0] wv;
    int r;
    iv = p[3:0];
    wv = p[7:4];
    r = int'(iv) * int'(wv);
    return 16'(r);
  endfunction

  function automatic logic [15:0] mac_relu(input logic [15:0] v);
    return v[15] ? 16'h0000 : v;
  endfunction

  // Behavioural MAC: synchronous clear, wrapping accumulate, combinational ReLU.
  always @(posedge clk) begin
    if (!rst_n || acc_clr) mac_total <= 16'h0000;
    else                   mac_total <= mac_total + mac_prod(pair_out);
  end
  assign relu_in = mac_relu(mac_total + mac_prod(pair_out));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    tests      = 0;
    failures   = 0;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_last  = 1'b0;
    start      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_pair_out", pair_out, 0);
    checkOutput("rst_pair_valid", pair_valid, 0);
    checkOutput("rst_acc_clr", acc_clr, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_result_valid", result_valid, 0);
    checkOutput("rst_load_ready", load_ready, 1);

    // start with an empty buffer is ignored
    start = 1'b1;
    #1;
    checkOutput("empty_start_ready", load_ready, 0);
    tick();
    start = 1'b0;
    checkOutput("empty_start_busy", busy, 0);
    checkOutput("empty_start_clr", acc_clr, 0);

    // basic run: (i=3,w=2), (i=-1,w=4)
    applyStimulus(8'h23, 1'b0);
    applyStimulus(8'h4F, 1'b1);
    checkOutput("basic_count", count, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("basic_c1_clr", acc_clr, 1);
    checkOutput("basic_c1_busy", busy, 1);
    checkOutput("basic_c1_pair", pair_out, 0);
    tick();
    checkOutput("basic_c2_pair", pair_out, 8'h23);
    checkOutput("basic_c2_valid", pair_valid, 1);
    checkOutput("basic_c2_clr", acc_clr, 0);
    tick();
    checkOutput("basic_c3_pair", pair_out, 8'h4F);
    tick();
    checkOutput("basic_c4_pair", pair_out, 0);
    checkOutput("basic_c4_valid", pair_valid, 0);
    checkOutput("basic_c4_busy", busy, 1);
    checkOutput("basic_c4_rv", result_valid, 0);
    tick();
    checkOutput("basic_c5_rv", result_valid, 1);
    checkOutput("basic_c5_result", result, 2);
    checkOutput("basic_c5_busy", busy, 0);
    tick();
    checkOutput("basic_c6_rv", result_valid, 0);
    checkOutput("basic_c6_hold", result, 2);

    // replay, holding start through the busy window (cycles 1..4)
    start = 1'b1;
    tick();
    checkOutput("replay_c1_clr", acc_clr, 1);
    tick();
    checkOutput("replay_c2_pair", pair_out, 8'h23);
    tick();
    checkOutput("replay_c3_pair", pair_out, 8'h4F);
    tick();
    start = 1'b0;
    checkOutput("replay_c4_busy", busy, 1);
    checkOutput("replay_c4_clr", acc_clr, 0);
    tick();
    checkOutput("replay_c5_rv", result_valid, 1);
    checkOutput("replay_c5_result", result, 2);
    tick();
    checkOutput("replay_c6_busy", busy, 0);
    checkOutput("replay_c6_clr", acc_clr, 0);
    checkOutput("replay_count", count, 2);

    // negative total: (i=-8,w=7) -> -56, new beat restarts count at 1
    applyStimulus(8'h78, 1'b1);
    checkOutput("neg_count", count, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("neg_c1_clr", acc_clr, 1);
    tick();
    checkOutput("neg_c2_pair", pair_out, 8'h78);
    tick();
    checkOutput("neg_c3_busy", busy, 1);
    tick();
    checkOutput("neg_c4_rv", result_valid, 1);
    checkOutput("neg_c4_result", result, 0);
`ifdef MLP_FEED_CHECK_EN
    checkOutput("neg_c4_check_err", check_err, 0);
`endif
    tick();

    // start and load in the same cycle: beat dropped, run proceeds
    start      = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h11;
    load_last  = 1'b1;
    #1;
    checkOutput("conf_ready", load_ready, 0);
    tick();
    start      = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    checkOutput("conf_count", count, 1);
    checkOutput("conf_busy", busy, 1);
    tick();
    checkOutput("conf_c2_pair", pair_out, 8'h78);
    tick();
    tick();
    checkOutput("conf_c4_rv", result_valid, 1);
    checkOutput("conf_c4_result", result, 0);
    tick();

    // full buffer: 8 x (i=-8,w=-8) -> 8*64 = 512
    for (int k = 0; k < 8; k++) begin
      applyStimulus(8'h88, 1'b0);
    end
    checkOutput("full_count", count, 8);
    checkOutput("full_ready", load_ready, 0);
    applyStimulus(8'h12, 1'b0);
    checkOutput("full_overflow_count", count, 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      tick();
    end
    checkOutput("full_c10_busy", busy, 1);
    checkOutput("full_c10_pair", pair_out, 0);
    tick();
    checkOutput("full_c11_rv", result_valid, 1);
    checkOutput("full_c11_result", result, 16'd512);
    tick();

    // reset during STREAM aborts the run
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checkOutput("abort_streaming", pair_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_pair_valid", pair_valid, 0);
    checkOutput("abort_pair_out", pair_out, 0);
    checkOutput("abort_count", count, 0);
    checkOutput("abort_result", result, 0);
    checkOutput("abort_rv", result_valid, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("abort_no_rv", result_valid, 0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("abort_start_empty_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/mlp_feed_ctrl.md
# mlp_feed_ctrl

Sequencer that drives the single-neuron MAC (signed 4b×4b product into a 16-bit wrapping accumulator with ReLU output). It buffers a vector of (input, weight) nibble pairs and, on `start`, pulses the accumulator clear and streams one pair per cycle into the MAC. It then captures the MAC's 16-bit ReLU result. It sits between the host-side byte interface and the MAC inside the top-level tile.

## Interface
- `N_TERMS`, default 8: buffer depth in pairs, i.e. the maximum vector length; must be ≥1.
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `load_valid`  in  1  host presents a pair.
- `load_ready`  out  1  pair accepted when `load_valid && load_ready`.
- `load_data`  in  8  `{w[3:0], i[3:0]}`, both two's-complement.
- `load_last`  in  1  marks the final pair of the vector.
- `start`  in  1  run request, level-sampled.
- `busy`  out  1  high from CLEAR through DRAIN.
- `count`  out  clog2(N_TERMS+1)  pairs currently buffered.
- `pair_out`  out  8  `{w,i}` to the MAC; 0 whenever not streaming.
- `pair_valid`  out  1  high during STREAM only.
- `acc_clr`  out  1  one-cycle pulse; top level ORs it into the MAC accumulator synchronous clear.
- `relu_in`  in  16  MAC ReLU output, combinational from the MAC's registered total plus the current product.
- `result`  out  16  captured ReLU result; holds until the next capture.
- `result_valid`  out  1  one-cycle pulse.

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN.
- **IDLE**
  - `load_ready = !start && count < N_TERMS`.
  - An accepted beat writes `buf[count]` and increments `count`.
  - `load_last` on an accepted beat seals the vector.
  - The first accepted beat after seal resets `count` to 0 before writing, so that beat is stored at index 0 and `count` becomes 1. It also clears seal.
  - Reaching `count == N_TERMS` seals implicitly.
- **start in IDLE**
  - With `count > 0`: go to CLEAR. `start` has priority over a same-cycle load; that beat is not accepted.
  - With `count == 0`: ignored.
  - Outside IDLE: ignored.
- **CLEAR**: `acc_clr = 1` for one cycle, `pair_out = 0`. Go to STREAM with `idx = 0`.
- **STREAM**
  - `pair_out = buf[idx]`, `pair_valid = 1`, `idx` increments.
  - After `idx == count-1`, go to DRAIN.
- **DRAIN**
  - `pair_out = 0`, so the product is 0 and `relu_in = relu(total)`.
  - `result <= relu_in`, `result_valid` is pulsed next cycle, return to IDLE.
- Buffer and `count` are retained after a run, so re-asserting `start` replays the same vector.
- No arithmetic in the datapath. Pairs pass through unmodified. The MAC wraps mod 2^16; the sequencer does not saturate.
- Reset values:
  - State IDLE; `count`, `idx`, `result`, `pair_out` = 0.
  - `pair_valid`, `acc_clr`, `result_valid`, `busy` = 0; seal clear.
  - `load_ready` = 1 (combinational, since `count = 0`), unless `start` is high.
  - Buffer contents are don't-care.
- Reset mid-run aborts immediately. No `result_valid` is produced and the buffered vector is lost.

## Timing
- `start` sampled at cycle 0 with `count = K`:
  - Cycle 1: CLEAR.
  - Cycles 2..K+1: STREAM.
  - Cycle K+2: DRAIN.
  - Cycle K+3: `result_valid = 1`, `result` valid, state IDLE.
- `busy` is high in cycles 1..K+2.
- A new `start` is accepted in cycle K+3.
- The MAC's clear takes effect at the end of cycle 1, so the first pair accumulates onto 0.
- `pair_out`, `pair_valid`, `acc_clr`, `busy` are registered outputs. `load_ready` is combinational.

## Configuration
- `MLP_FEED_CHECK_EN`, when defined:
  - Instantiates a shadow accumulator that computes the 16-bit wrapping sum of signed `i*w` over streamed pairs, then applies ReLU (positive → value, else 0).
  - Adds output `check_err` (1 bit), registered alongside `result_valid`. It is high when the shadow value ≠ `relu_in` at DRAIN and is cleared on the next `start`. Its reset value is 0.
- When undefined: no shadow logic and no `check_err` port.

## Structure
- Package `mlp_feed_pkg`:
  - State enum.
  - `PAIR_W = 8`, `NIB_W = 4`, `ACC_W = 16`.
  - ReLU helper function, shared with the checker.
- Sub-module `mlp_feed_check` holds the shadow accumulator and is instantiated only under `MLP_FEED_CHECK_EN`.
- The buffer is a flop array inside `mlp_feed_ctrl`.

## Test plan
The bench includes a behavioural MAC model wired to `pair_out` and `acc_clr`.
- **Basic run**: load (i=3,w=2), (i=-1,w=4, last); start → `pair_out` 0x23 then 0x4F in cycles 2–3, `result = 2` with `result_valid` at cycle 5.
- **Negative total**: load (i=-8,w=7, last); start → total −56, `result = 0` at cycle 4; `check_err = 0` if enabled.
- **Full buffer**: load 8 pairs of (i=-8,w=-8) without `last` → `load_ready` drops at `count = 8`; start → `result = 512` at cycle 11.
- **Replay**: after a run, start again without loading → identical `pair_out` sequence and `result`. Then load one new beat → `count` restarts at 1.
- **Conflicts**:
  - start with `count = 0` → no `busy`.
  - start and `load_valid` in the same cycle → beat not accepted, run proceeds.
  - start during `busy` → ignored.
- **Reset during STREAM**: all outputs return to reset values next cycle, `count = 0`, no `result_valid`.
